// File: rtl/score_pkg.sv
// Shared types and constants for the score controller: FSM state encoding,
// winner encodings and the saturating score increment.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic [7:0] SCORE_MAX = 8'd99;

    // Scores stop at SCORE_MAX instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] s);
        return (s >= SCORE_MAX) ? SCORE_MAX : s + 8'd1;
    endfunction

endpackage

// File: rtl/serve_timer.sv
// Pre-serve pause counter: load sets it to SERVE_CYCLES-1, count-enable
// walks it down to zero, done flags zero.
module serve_timer #(
    parameter int SERVE_CYCLES = 50_000_000,
    localparam int W = $clog2(SERVE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic cnt_en_i,
    output logic done_o
);

    localparam logic [W-1:0] LOAD_VAL = W'(SERVE_CYCLES - 1);

    logic [W-1:0] count_q;

    // Count register: reset clears, load wins over decrement, holds at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= LOAD_VAL;
        end else if (cnt_en_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/score_controller.sv
// Two-player score keeper and serve sequencer (IDLE/SERVE/PLAY/OVER).
// Optional macro WIN_BY_TWO_EN: when defined, a player must reach WIN_SCORE
// with a lead of at least two (or reach 99) to win; otherwise reaching
// WIN_SCORE exactly wins.
module score_controller
    import score_pkg::*;
#(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_CYCLES = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic [7:0] p1_score,
    output logic [7:0] p2_score,
    output logic       serve_en,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [7:0] WIN_B = 8'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [7:0] p1_score_q, p1_score_d;
    logic [7:0] p2_score_q, p2_score_d;
    logic       serve_en_q, serve_en_d;
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q, winner_d;

    logic       p1_only, p2_only, both_pts;
    logic [7:0] p1_inc, p2_inc;
    logic       p1_wins, p2_wins;
    logic       timer_load, timer_cnt_en, timer_done;

    assign p1_only  = p1_point & ~p2_point;
    assign p2_only  = p2_point & ~p1_point;
    assign both_pts = p1_point & p2_point;
    assign p1_inc   = sat_inc(p1_score_q);
    assign p2_inc   = sat_inc(p2_score_q);

`ifdef WIN_BY_TWO_EN
    assign p1_wins = ((p1_inc >= WIN_B) && (p1_inc >= p2_score_q + 8'd2)) || (p1_inc == SCORE_MAX);
    assign p2_wins = ((p2_inc >= WIN_B) && (p2_inc >= p1_score_q + 8'd2)) || (p2_inc == SCORE_MAX);
`else
    assign p1_wins = (p1_inc == WIN_B);
    assign p2_wins = (p2_inc == WIN_B);
`endif

    // The pause is reloaded on every entry into SERVE, including replays.
    assign timer_load   = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    assign timer_cnt_en = (state_q == ST_SERVE);

    serve_timer #(
        .SERVE_CYCLES(SERVE_CYCLES)
    ) u_serve_timer (
        .clock    (clock),
        .reset    (reset),
        .load_i   (timer_load),
        .cnt_en_i (timer_cnt_en),
        .done_o   (timer_done)
    );

    // State and registered outputs; reset overrides every input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            p1_score_q  <= '0;
            p2_score_q  <= '0;
            serve_en_q  <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= WIN_NONE;
        end else begin
            state_q     <= state_d;
            p1_score_q  <= p1_score_d;
            p2_score_q  <= p2_score_d;
            serve_en_q  <= serve_en_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    // Next-state logic: start only matters in IDLE/OVER, points only in PLAY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SERVE;
            ST_SERVE: if (timer_done) state_d = ST_PLAY;
            ST_PLAY: begin
                if (both_pts)     state_d = ST_SERVE;
                else if (p1_only) state_d = p1_wins ? ST_OVER : ST_SERVE;
                else if (p2_only) state_d = p2_wins ? ST_OVER : ST_SERVE;
            end
            ST_OVER:  if (start) state_d = ST_SERVE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next output values, registered alongside the state.
    always_comb begin
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        winner_d   = winner_q;
        case (state_q)
            ST_PLAY: begin
                if (p1_only) begin
                    p1_score_d = p1_inc;
                    if (p1_wins) winner_d = WIN_P1;
                end else if (p2_only) begin
                    p2_score_d = p2_inc;
                    if (p2_wins) winner_d = WIN_P2;
                end
            end
            ST_OVER: begin
                if (start) begin
                    p1_score_d = '0;
                    p2_score_d = '0;
                    winner_d   = WIN_NONE;
                end
            end
            default: ;
        endcase
        serve_en_d  = (state_d == ST_PLAY);
        game_over_d = (state_d == ST_OVER);
    end

    assign p1_score  = p1_score_q;
    assign p2_score  = p2_score_q;
    assign serve_en  = serve_en_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_score_controller.sv
// Bench for score_controller with SERVE_CYCLES=4, WIN_SCORE=3.
module tb_score_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       p1_point = 1'b0;
    logic       p2_point = 1'b0;
    logic [7:0] p1_score, p2_score;
    logic       serve_en, game_over;
    logic [1:0] winner;

    int checks = 0;
    int failures = 0;

    score_controller #(
        .WIN_SCORE(3),
        .SERVE_CYCLES(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .p1_point  (p1_point),
        .p2_point  (p2_point),
        .p1_score  (p1_score),
        .p2_score  (p2_score),
        .serve_en  (serve_en),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst, st, a, b;
        logic [7:0] ep1, ep2;
        logic       ese, ego;
        logic [1:0] ew;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic a, input logic b,
                                input logic [7:0] e1, input logic [7:0] e2,
                                input logic se, input logic go, input logic [1:0] w);
        vec_t v;
        v.rst = r; v.st = s; v.a = a; v.b = b;
        v.ep1 = e1; v.ep2 = e2; v.ese = se; v.ego = go; v.ew = w;
        vecs.push_back(v);
    endfunction

    // Remaining three SERVE cycles after entry, then the first PLAY cycle.
    function automatic void add_pause(input logic [7:0] e1, input logic [7:0] e2);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, e1, e2, 0, 0, 2'b00);
        add(0, 0, 0, 0, e1, e2, 1, 0, 2'b00);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic a, input logic b);
        @(negedge clock);
        reset = r; start = s; p1_point = a; p2_point = b;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_play();
        int n = 0;
        while (!serve_en && n < 12) begin
            step(0, 0, 0, 0);
            n++;
        end
        chk("wait_play", 32'(serve_en), 32'd1);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                           input logic go, input logic [1:0] w);
        chk({tag, ".p1"}, 32'(p1_score), 32'(e1));
        chk({tag, ".p2"}, 32'(p2_score), 32'(e2));
        chk({tag, ".go"}, 32'(game_over), 32'(go));
        chk({tag, ".win"}, 32'(winner), 32'(w));
    endtask

    initial begin
        // reset, start, 4-cycle pause
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        add(0, 1, 0, 0, 0, 0, 0, 0, 2'b00);
        add_pause(0, 0);
        // three p1 points to a win
        add(0, 0, 1, 0, 1, 0, 0, 0, 2'b00); add_pause(1, 0);
        add(0, 0, 1, 0, 2, 0, 0, 0, 2'b00); add_pause(2, 0);
        add(0, 0, 1, 0, 3, 0, 0, 1, 2'b01);
        add(0, 0, 0, 1, 3, 0, 0, 1, 2'b01);
        add(0, 0, 0, 1, 3, 0, 0, 1, 2'b01);
        // restart from OVER, p2 point during SERVE ignored
        add(0, 1, 0, 0, 0, 0, 0, 0, 2'b00);
        add(0, 0, 0, 1, 0, 0, 0, 0, 2'b00);
        add(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        add(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        add(0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
        // start ignored in PLAY, simultaneous points replay
        add(0, 1, 0, 0, 0, 0, 1, 0, 2'b00);
        add(0, 0, 1, 1, 0, 0, 0, 0, 2'b00); add_pause(0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 2'b00); add_pause(0, 1);
        add(0, 0, 1, 0, 1, 1, 0, 0, 2'b00); add_pause(1, 1);
        add(0, 0, 1, 0, 2, 1, 0, 0, 2'b00); add_pause(2, 1);
        // reset in PLAY at 2/1 beats a simultaneous point
        add(1, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        add(0, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        // reset beats start: stays IDLE, no pause completes
        add(1, 1, 0, 0, 0, 0, 0, 0, 2'b00);
        for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        // reset mid-pause, then a fresh full pause
        add(0, 1, 0, 0, 0, 0, 0, 0, 2'b00);
        add(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        add(0, 1, 0, 0, 0, 0, 0, 0, 2'b00);
        add_pause(0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d.p1", i), 32'(p1_score), 32'(vecs[i].ep1));
            chk($sformatf("v%0d.p2", i), 32'(p2_score), 32'(vecs[i].ep2));
            chk($sformatf("v%0d.se", i), 32'(serve_en), 32'(vecs[i].ese));
            chk($sformatf("v%0d.go", i), 32'(game_over), 32'(vecs[i].ego));
            chk($sformatf("v%0d.win", i), 32'(winner), 32'(vecs[i].ew));
        end

        // fresh game for the win-rule sequence
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        wait_play();
`ifdef WIN_BY_TWO_EN
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0); wait_play();
            step(0, 0, 0, 1); wait_play();
        end
        chk_out("deuce", 3, 3, 0, 2'b00);
        step(0, 0, 1, 0);
        chk_out("adv", 4, 3, 0, 2'b00);
        wait_play();
        step(0, 0, 1, 0);
        chk_out("win2", 5, 3, 1, 2'b01);
`else
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 1, 0); wait_play();
            step(0, 0, 0, 1); wait_play();
        end
        chk_out("even", 2, 2, 0, 2'b00);
        step(0, 0, 0, 1);
        chk_out("p2win", 2, 3, 1, 2'b10);
        chk("p2win.se", 32'(serve_en), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_controller.md
SCORE_CONTROLLER -- requirements
Module: score_controller

Interface
- REQ-001: Parameter WIN_SCORE, default 11; points needed to win; legal range 1..99.
- REQ-002: Parameter SERVE_CYCLES, default 50_000_000; length of the pre-serve pause in clock cycles; minimum 1.
- REQ-003: Port clock, input, 1; the single system clock.
- REQ-004: Port reset, input, 1; synchronous, active-high reset.
- REQ-005: Port start, input, 1; one-cycle pulse that begins a new game.
- REQ-006: Port p1_point, input, 1; one-cycle pulse meaning player 1 scored.
- REQ-007: Port p2_point, input, 1; one-cycle pulse meaning player 2 scored.
- REQ-008: Port p1_score, output, 8; player 1 score, binary 0..99, drives the HEX score display.
- REQ-009: Port p2_score, output, 8; player 2 score, binary 0..99, drives the HEX score display.
- REQ-010: Port serve_en, output, 1; high only while the ball may move.
- REQ-011: Port game_over, output, 1; high while in OVER.
- REQ-012: Port winner, output, 2; 00 none, 01 player 1, 10 player 2; 11 never driven.

Function
- REQ-013: FSM states SHALL be IDLE, SERVE, PLAY and OVER.
- IDLE: serve_en=0, scores=0; on start go to SERVE.
- SERVE: serve_en=0; serve timer loaded with SERVE_CYCLES-1 on entry, decrements each cycle; at 0 go to PLAY.
- PLAY: serve_en=1; handles point pulses.
- OVER: serve_en=0, game_over=1, winner held; on start clear scores and winner, go to SERVE.
- REQ-014: In PLAY, a single point pulse on cycle N SHALL make the incremented score visible on cycle N+1, with the state on N+1 being OVER if the win rule holds, otherwise SERVE.
- REQ-015: Win rule (macro absent): the scorer wins when its new score equals WIN_SCORE.
- REQ-016: p1_point and p2_point asserted together in PLAY SHALL change neither score and SHALL send the FSM to SERVE (replay).
- REQ-017: Point pulses in IDLE, SERVE or OVER SHALL be ignored.
- REQ-018: start asserted in SERVE or PLAY SHALL be ignored.
- REQ-019: Scores SHALL saturate at 99 and never wrap.
- REQ-020: winner SHALL be 00 in every state except OVER.
- REQ-021: All outputs SHALL be registered.

Reset
- REQ-022: reset SHALL force, on the next clock edge and from any state including mid-pause or mid-point: state IDLE, p1_score=0, p2_score=0, serve_en=0, game_over=0, winner=00, serve timer=0.
- REQ-023: reset SHALL take priority over start and both point inputs on the same cycle.

Configuration
- REQ-024: Macro WIN_BY_TWO_EN selects the win rule.
- Defined: the scorer wins when its new score is at least WIN_SCORE and leads the opponent by at least 2, or when its new score reaches 99.
- Undefined: REQ-015 applies.

Structure
- REQ-025: Package score_pkg SHALL hold the state enum typedef, the winner encodings (WIN_NONE, WIN_P1, WIN_P2) and the constant SCORE_MAX=99.
- REQ-026: The pause counter SHALL be the sub-module serve_timer, with load, count-enable and done, and width $clog2(SERVE_CYCLES+1).

Verification (bench uses SERVE_CYCLES=4, WIN_SCORE=3)
- REQ-027: reset, then start -> serve_en rises exactly 4 cycles after SERVE is entered; scores read 0/0.
- REQ-028: three p1_point pulses, each issued in PLAY -> p1_score 1, 2, 3, each one cycle after its pulse; after the third, game_over=1 and winner=01; later p2_point pulses leave p2_score=0.
- REQ-029: p1_point and p2_point in the same PLAY cycle -> scores unchanged, state SERVE, serve_en=0 for 4 cycles.
- REQ-030: p2_point during SERVE -> p2_score unchanged; start in OVER -> scores 0/0, winner=00, back to SERVE.
- REQ-031: reset asserted in PLAY at score 2/1 -> next cycle IDLE with 0/0, serve_en=0, game_over=0.
- REQ-032: WIN_BY_TWO_EN defined, score driven to 3/3 then one p1_point -> 4/3 and no game over; a second p1_point -> 5/3, game_over=1, winner=01.
